// File: rtl/alu_operand_serdes_if.sv
// Bus and ALU-side signals of alu_operand_serdes.
// The master modport is the serdes side, and the slave modport is the bus/ALU side.
interface alu_operand_serdes_if #(
  parameter int NSHIFT  = 2,
  parameter int IO_BITS = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [IO_BITS-1:0] in_data;
  logic               arg_valid;
  logic               active;
  logic               op_done;
  logic [NSHIFT-1:0]  data_in2;
  logic [NSHIFT-1:0]  data_out;
  logic               out_valid;
  logic               out_ready;
  logic [IO_BITS-1:0] out_data;

  modport master (
    input  in_valid, in_data, active, op_done, data_out, out_ready,
    output in_ready, arg_valid, data_in2, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, active, op_done, data_out, out_ready,
    input  in_ready, arg_valid, data_in2, out_valid, out_data
  );
endinterface

// File: rtl/alu_operand_serdes.sv
// Operand/result serializer between the nibble memory bus and the serial ALU.
// Define SERDES_LEN_CHECK_EN to let op_done end RUN and flag length mismatches on len_err.
module alu_operand_serdes #(
  parameter int REG_BITS = 8,
  parameter int NSHIFT   = 2,
  parameter int IO_BITS  = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic pair,
  input  logic load_en,
  input  logic store_en,
  output logic busy,
  output logic len_err,
  alu_operand_serdes_if.master bus
);

  localparam int W_MAX = 2 * REG_BITS;
  localparam int CNT_W = $clog2(W_MAX / NSHIFT + 1);

  typedef enum logic [1:0] {IDLE, FILL, RUN, DRAIN} state_t;

  state_t             state;
  logic [W_MAX-1:0]   shift_buf;
  logic [CNT_W-1:0]   cnt;
  logic               pair_q;
  logic               store_q;
  logic [CNT_W-1:0]   nib_last;
  logic [CNT_W-1:0]   run_last;
  logic               run_last_hit;
  logic               run_end;

  // The last count index depends on the operand width latched at start.
  always_comb begin
    nib_last = pair_q ? CNT_W'(W_MAX / IO_BITS - 1) : CNT_W'(REG_BITS / IO_BITS - 1);
    run_last = pair_q ? CNT_W'(W_MAX / NSHIFT - 1)  : CNT_W'(REG_BITS / NSHIFT - 1);
  end

  assign run_last_hit = bus.active && (cnt == run_last);

`ifdef SERDES_LEN_CHECK_EN
  logic len_q;
  assign run_end = bus.op_done || run_last_hit;
  assign len_err = len_q;
`else
  wire unused_op_done = bus.op_done;
  assign run_end = run_last_hit;
  assign len_err = 1'b0;
`endif

  assign busy          = (state != IDLE);
  assign bus.in_ready  = (state == FILL);
  assign bus.arg_valid = (state == RUN);
  assign bus.out_valid = (state == DRAIN);
  assign bus.data_in2  = shift_buf[NSHIFT-1:0];
  assign bus.out_data  = shift_buf[IO_BITS-1:0];

  // One shared counter, cleared on every transition, paces the fill, run and drain phases.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_buf <= '0;
      cnt       <= '0;
      pair_q    <= 1'b0;
      store_q   <= 1'b0;
`ifdef SERDES_LEN_CHECK_EN
      len_q     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            shift_buf <= '0;
            cnt       <= '0;
            pair_q    <= pair;
            store_q   <= store_en;
`ifdef SERDES_LEN_CHECK_EN
            len_q     <= 1'b0;
`endif
            state     <= load_en ? FILL : RUN;
          end
        end
        FILL: begin
          if (bus.in_valid) begin
            for (int i = 0; i < W_MAX / IO_BITS; i++) begin
              if (cnt == CNT_W'(i)) shift_buf[i*IO_BITS +: IO_BITS] <= bus.in_data;
            end
            if (cnt == nib_last) begin
              cnt   <= '0;
              state <= RUN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        RUN: begin
          // Single-byte operands shift only the low byte, so the high byte stays zero.
          if (bus.active) begin
            if (pair_q) shift_buf <= {bus.data_out, shift_buf[W_MAX-1:NSHIFT]};
            else        shift_buf <= {{REG_BITS{1'b0}}, bus.data_out, shift_buf[REG_BITS-1:NSHIFT]};
            cnt <= cnt + 1'b1;
          end
          if (run_end) begin
            cnt   <= '0;
            state <= store_q ? DRAIN : IDLE;
`ifdef SERDES_LEN_CHECK_EN
            if (bus.op_done != run_last_hit) len_q <= 1'b1;
`endif
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            shift_buf <= shift_buf >> IO_BITS;
            if (cnt == nib_last) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
